// File: rtl/reduce_result_fifo.sv
// reduce_result_fifo: buffers completed reduction sums from a producer that
// cannot be stalled. Words go into a first-word-fall-through FIFO and leave
// over a ready/valid handshake. A capture that arrives while the FIFO is full
// and not popping is dropped, and the drop is recorded in sticky statistics.
module reduce_result_fifo #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4,
  parameter int CAPTURE_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  input  logic                     clr_stats
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              prev_valid_q;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic              cap_s, pop_s, push_s, drop_s;

  // Capture, pop, push and drop strobes derived only from registered state and inputs.
  always_comb begin
    if (CAPTURE_MODE == 1) begin
      cap_s = in_valid & ~prev_valid_q;
    end else begin
      cap_s = in_valid;
    end
    pop_s  = ~empty_q & out_ready;
    // A full FIFO still accepts a capture when its head leaves on the same edge.
    push_s = cap_s & (~full_q | pop_s);
    drop_s = cap_s & full_q & ~pop_s;
  end

  // Next pointers, occupancy and the registered full/empty flags.
  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == LW'(0));
  end

  // Sticky overflow flag and saturating drop counter; a drop wins over a clear.
  always_comb begin
    if (drop_s) begin
      overflow_d = 1'b1;
      if (clr_stats) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else if (clr_stats) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Control and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      level_q      <= {LW{1'b0}};
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      prev_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= 16'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      prev_valid_q <= in_valid;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Storage array; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = ~empty_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_reduce_result_fifo.sv
// Bench for reduce_result_fifo: one instance per capture mode, a queue-based
// reference model, a per-cycle compare process, directed literal checks and
// a randomized phase.
module tb_reduce_result_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] id0, id1, od0, od1;
  logic iv0, iv1, rd0, rd1, clr0, clr1;
  logic ov_o0, ov_o1, fu0, fu1, em0, em1, of0, of1;
  logic [2:0] lvl0, lvl1;
  logic [15:0] dc0, dc1;

  reduce_result_fifo #(.DATA_W(32), .DEPTH(4), .CAPTURE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(id0), .in_valid(iv0), .out_data(od0),
    .out_valid(ov_o0), .out_ready(rd0), .full(fu0), .empty(em0), .level(lvl0),
    .overflow(of0), .drop_count(dc0), .clr_stats(clr0));

  reduce_result_fifo #(.DATA_W(32), .DEPTH(4), .CAPTURE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(id1), .in_valid(iv1), .out_data(od1),
    .out_valid(ov_o1), .out_ready(rd1), .full(fu1), .empty(em1), .level(lvl1),
    .overflow(of1), .drop_count(dc1), .clr_stats(clr1));

  // Reference model state.
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic        mov0, mov1, mprev1;
  logic [15:0] mdc0, mdc1;

  int n_tot  = 0;
  int n_pass = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of the reference model, using the inputs held across the edge.
  task automatic model_step();
    bit cap, pop, full, drop, push;
    if (rst) begin
      mq0.delete(); mov0 = 1'b0; mdc0 = 16'd0;
      mq1.delete(); mov1 = 1'b0; mdc1 = 16'd0; mprev1 = 1'b0;
    end else begin
      cap  = iv0;
      pop  = (mq0.size() != 0) && rd0;
      full = (mq0.size() == 4);
      drop = cap && full && !pop;
      push = cap && (!full || pop);
      if (pop) void'(mq0.pop_front());
      if (push) mq0.push_back(id0);
      if (drop) begin
        mov0 = 1'b1;
        mdc0 = clr0 ? 16'd1 : ((mdc0 == 16'hFFFF) ? mdc0 : mdc0 + 16'd1);
      end else if (clr0) begin
        mov0 = 1'b0; mdc0 = 16'd0;
      end

      cap    = iv1 && !mprev1;
      mprev1 = iv1;
      pop    = (mq1.size() != 0) && rd1;
      full   = (mq1.size() == 4);
      drop   = cap && full && !pop;
      push   = cap && (!full || pop);
      if (pop) void'(mq1.pop_front());
      if (push) mq1.push_back(id1);
      if (drop) begin
        mov1 = 1'b1;
        mdc1 = clr1 ? 16'd1 : ((mdc1 == 16'hFFFF) ? mdc1 : mdc1 + 16'd1);
      end else if (clr1) begin
        mov1 = 1'b0; mdc1 = 16'd0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid0", {31'd0, ov_o0}, {31'd0, (mq0.size() != 0)});
      chk("empty0", {31'd0, em0},   {31'd0, (mq0.size() == 0)});
      chk("full0",  {31'd0, fu0},   {31'd0, (mq0.size() == 4)});
      chk("level0", {29'd0, lvl0},  32'(mq0.size()));
      chk("ovf0",   {31'd0, of0},   {31'd0, mov0});
      chk("drops0", {16'd0, dc0},   {16'd0, mdc0});
      if (mq0.size() != 0) chk("data0", od0, mq0[0]);
      chk("valid1", {31'd0, ov_o1}, {31'd0, (mq1.size() != 0)});
      chk("empty1", {31'd0, em1},   {31'd0, (mq1.size() == 0)});
      chk("full1",  {31'd0, fu1},   {31'd0, (mq1.size() == 4)});
      chk("level1", {29'd0, lvl1},  32'(mq1.size()));
      chk("ovf1",   {31'd0, of1},   {31'd0, mov1});
      chk("drops1", {16'd0, dc1},   {16'd0, mdc1});
      if (mq1.size() != 0) chk("data1", od1, mq1[0]);
    end
  end

  logic [31:0] exp_drain [4];
  int dens, rdp;

  initial begin
    exp_drain = '{32'hA1, 32'hA2, 32'hA3, 32'hCC};
    rst = 1'b1; id0 = 32'd0; id1 = 32'd0; iv0 = 1'b0; iv1 = 1'b0;
    rd0 = 1'b0; rd1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    mov0 = 1'b0; mov1 = 1'b0; mdc0 = 16'd0; mdc1 = 16'd0; mprev1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_level", {29'd0, lvl0}, 32'd0);
    chk("rst_empty", {31'd0, em0}, 32'd1);
    chk("rst_full", {31'd0, fu0}, 32'd0);
    chk("rst_valid", {31'd0, ov_o0}, 32'd0);
    chk("rst_ovf", {31'd0, of0}, 32'd0);
    chk("rst_drops", {16'd0, dc0}, 32'd0);
    chk("rst_data", od0, 32'd0);

    // Basic pass-through
    rd0 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      iv0 = 1'b1; id0 = 32'h10 * i;
      tick();
      chk("pt_valid", {31'd0, ov_o0}, 32'd1);
      chk("pt_data", od0, 32'h10 * i);
      chk("pt_level", {29'd0, lvl0}, 32'd1);
      iv0 = 1'b0;
      tick();
      chk("pt_gone", {31'd0, ov_o0}, 32'd0);
      tick();
    end

    // Fill and drain
    rd0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv0 = 1'b1; id0 = 32'hA0 + i; tick();
    end
    iv0 = 1'b0;
    chk("fill_full", {31'd0, fu0}, 32'd1);
    chk("fill_level", {29'd0, lvl0}, 32'd4);

    // Overflow: two drops while full and stalled
    iv0 = 1'b1; id0 = 32'hBB; tick(); tick(); iv0 = 1'b0;
    chk("ovf_flag", {31'd0, of0}, 32'd1);
    chk("ovf_count", {16'd0, dc0}, 32'd2);
    chk("ovf_head", od0, 32'hA0);
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    chk("clr_flag", {31'd0, of0}, 32'd0);
    chk("clr_count", {16'd0, dc0}, 32'd0);

    // Full with simultaneous pop and capture
    rd0 = 1'b1; iv0 = 1'b1; id0 = 32'hCC; tick(); iv0 = 1'b0;
    chk("fp_level", {29'd0, lvl0}, 32'd4);
    chk("fp_drops", {16'd0, dc0}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("fp_drain", od0, exp_drain[i]);
      tick();
    end
    chk("fp_empty", {31'd0, em0}, 32'd1);

    // Clear and drop in the same cycle
    rd0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv0 = 1'b1; id0 = 32'hD0 + i; tick();
    end
    tick(); tick();
    clr0 = 1'b1; tick(); clr0 = 1'b0; iv0 = 1'b0;
    chk("clrdrop_flag", {31'd0, of0}, 32'd1);
    chk("clrdrop_count", {16'd0, dc0}, 32'd1);

    // Reset mid-operation
    rd0 = 1'b1; tick(); rd0 = 1'b0;
    chk("mid_level3", {29'd0, lvl0}, 32'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_level", {29'd0, lvl0}, 32'd0);
    chk("mid_valid", {31'd0, ov_o0}, 32'd0);
    chk("mid_ovf", {31'd0, of0}, 32'd0);
    chk("mid_drops", {16'd0, dc0}, 32'd0);
    iv0 = 1'b1; id0 = 32'h77; tick(); iv0 = 1'b0;
    chk("mid_push_valid", {31'd0, ov_o0}, 32'd1);
    chk("mid_push_data", od0, 32'h77);
    rd0 = 1'b1; tick(); rd0 = 1'b0;

    // Rising-edge capture mode
    iv1 = 1'b1; id1 = 32'h55;
    for (int i = 0; i < 10; i++) tick();
    iv1 = 1'b0; tick();
    iv1 = 1'b1; id1 = 32'h66;
    for (int i = 0; i < 3; i++) tick();
    iv1 = 1'b0; tick();
    chk("edge_level", {29'd0, lvl1}, 32'd2);
    chk("edge_first", od1, 32'h55);
    rd1 = 1'b1; tick();
    chk("edge_second", od1, 32'h66);
    tick();
    chk("edge_empty", {31'd0, em1}, 32'd1);
    rd1 = 1'b0;

    // Randomized traffic on both instances
    dens = 50; rdp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        dens = $urandom_range(10, 95);
        rdp  = $urandom_range(5, 95);
      end
      rst  = ($urandom_range(0, 599) == 0);
      iv0  = ($urandom_range(0, 99) < dens);
      id0  = $urandom;
      rd0  = ($urandom_range(0, 99) < rdp);
      clr0 = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) < 35) iv1 = ~iv1;
      id1  = $urandom;
      rd1  = ($urandom_range(0, 99) < rdp);
      clr1 = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0; iv0 = 1'b0; iv1 = 1'b0; rd0 = 1'b1; rd1 = 1'b1;
    clr0 = 1'b0; clr1 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
